// File: rtl/ibus_line_buffer_if.sv
// ibus_line_buffer_if
//   Carries both buses handled by the instruction line buffer:
//   - ibus side (core fetch port): ireq_valid/ireq_addr in,
//     iresp_addr_ok/iresp_data_ok/iresp_data out.
//   - cbus side (arbiter instruction input): icreq_* out to the arbiter,
//     icresp_* back from it.
//   Modports:
//     slave  - the line buffer itself (consumes ireq/icresp, drives iresp/icreq)
//     master - the surrounding core + arbiter (drives ireq/icresp)
interface ibus_line_buffer_if;
  // ibus request / response
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  // cbus request towards the arbiter
  logic        icreq_valid;
  logic        icreq_is_write;
  logic [2:0]  icreq_size;
  logic [31:0] icreq_addr;
  logic [3:0]  icreq_strobe;
  logic [31:0] icreq_data;
  logic [3:0]  icreq_len;

  // cbus response from the arbiter
  logic        icresp_okay;
  logic        icresp_ready;
  logic        icresp_last;
  logic [31:0] icresp_data;

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    output icreq_valid, icreq_is_write, icreq_size, icreq_addr,
           icreq_strobe, icreq_data, icreq_len,
    input  icresp_okay, icresp_ready, icresp_last, icresp_data
  );

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    input  icreq_valid, icreq_is_write, icreq_size, icreq_addr,
           icreq_strobe, icreq_data, icreq_len,
    output icresp_okay, icresp_ready, icresp_last, icresp_data
  );
endinterface

// File: rtl/ibus_line_buffer.sv
// ibus_line_buffer
//   Instruction-side ibus -> cbus converter with a one-line fetch buffer.
//   A cached miss fetches the whole line with one incrementing burst; later
//   fetches inside that line are answered in the same cycle with no bus
//   traffic. Addresses with addr[31:29] == 3'b101 are uncached and go out
//   as single-word reads that never touch the buffer.
// Parameters
//   LINE_WORDS  words per line (1/2/4/8/16), burst len = LINE_WORDS-1
// Ports
//   clk     clock, all state on posedge
//   resetn  asynchronous active-low reset
//   flush   invalidate the buffered line
//   bus     ibus + cbus signals (slave modport of ibus_line_buffer_if)
module ibus_line_buffer #(
  parameter int LINE_WORDS = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  ibus_line_buffer_if.slave  bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CNT_W = (LINE_WORDS > 1) ? OFF_W : 1;
  localparam int TAG_W = 30 - OFF_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);
  localparam logic [2:0] MSIZE4   = 3'b010;
  localparam logic [3:0] MLEN1    = 4'b0000;
  localparam logic [3:0] LINE_LEN = 4'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, SINGLE} state_t;

  state_t            state;
  logic              line_valid;
  logic              flush_pend;
  logic [TAG_W-1:0]  line_tag;
  logic [CNT_W-1:0]  counter;
  logic [31:0]       single_addr;
  logic [31:0]       line_data [LINE_WORDS];

  logic [TAG_W-1:0]  req_tag;
  logic [CNT_W-1:0]  req_word;
  logic              req_uncached;
  logic              req_hit;
  logic              single_ack;
  logic              unused_okay;

  // There is no bus-error path, so the okay flag is deliberately dropped.
  assign unused_okay = bus.icresp_okay;

  assign req_tag      = bus.ireq_addr[31 -: TAG_W];
  assign req_word     = (LINE_WORDS == 1) ? '0 : bus.ireq_addr[2 +: CNT_W];
  assign req_uncached = (bus.ireq_addr[31:29] == 3'b101);
  assign req_hit      = (state == IDLE) && bus.ireq_valid && line_valid &&
                        !req_uncached && (req_tag == line_tag);

  // A single read only answers the core if the request that started it is
  // still being presented; otherwise the returned word is thrown away.
  assign single_ack   = (state == SINGLE) && bus.icresp_ready &&
                        bus.ireq_valid && (bus.ireq_addr == single_addr);

  // Hits and single-read returns are answered in the cycle they happen, so
  // the ibus response is decoded combinationally from the registered state.
  always_comb begin
    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = '0;
    if (req_hit) begin
      bus.iresp_addr_ok = 1'b1;
      bus.iresp_data_ok = 1'b1;
      bus.iresp_data    = line_data[req_word];
    end else if (single_ack) begin
      bus.iresp_addr_ok = 1'b1;
      bus.iresp_data_ok = 1'b1;
      bus.iresp_data    = bus.icresp_data;
    end
  end

  // While filling, line_tag already holds the tag of the line being fetched
  // (line_valid is low), so the burst base is rebuilt from it.
  always_comb begin
    bus.icreq_valid    = (state != IDLE);
    bus.icreq_is_write = 1'b0;
    bus.icreq_size     = MSIZE4;
    bus.icreq_strobe   = '0;
    bus.icreq_data     = '0;
    bus.icreq_addr     = '0;
    bus.icreq_len      = MLEN1;
    case (state)
      FILL: begin
        bus.icreq_addr = {line_tag, {(OFF_W + 2){1'b0}}};
        bus.icreq_len  = LINE_LEN;
      end
      SINGLE: begin
        bus.icreq_addr = single_addr;
      end
      default: ;
    endcase
  end

  // Control FSM. A flush seen during a fill cannot abort the burst, so it is
  // parked in flush_pend and applied when the burst ends. A last beat that
  // arrives early leaves the line invalid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      line_valid  <= 1'b0;
      flush_pend  <= 1'b0;
      line_tag    <= '0;
      counter     <= '0;
      single_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) line_valid <= 1'b0;
          if (bus.ireq_valid && !req_hit) begin
            if (req_uncached) begin
              state       <= SINGLE;
              single_addr <= bus.ireq_addr;
            end else begin
              state      <= FILL;
              line_tag   <= req_tag;
              line_valid <= 1'b0;
              counter    <= '0;
              flush_pend <= 1'b0;
            end
          end
        end
        FILL: begin
          if (flush) flush_pend <= 1'b1;
          if (bus.icresp_ready) begin
            counter <= (counter == LAST_IDX) ? '0 : counter + 1'b1;
            if (bus.icresp_last) begin
              state      <= IDLE;
              line_valid <= (counter == LAST_IDX) && !flush_pend && !flush;
              flush_pend <= 1'b0;
            end
          end
        end
        SINGLE: begin
          if (flush) line_valid <= 1'b0;
          if (bus.icresp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage has no reset; it is only read once line_valid is set.
  always_ff @(posedge clk) begin
    if (state == FILL && bus.icresp_ready) begin
      line_data[counter] <= bus.icresp_data;
    end
  end

  fill_last_aligned: assert property (
    @(posedge clk) disable iff (!resetn)
    (state == FILL && bus.icresp_ready && bus.icresp_last) |-> (counter == LAST_IDX)
  );

endmodule
